// File: rtl/painterengine_gpu_writer_scheduler.sv
// Round-robin job scheduler sharing one painterengine_gpu_dma_writer among four channels.
// Each job is launched by pulsing the writer's reset, then supervised by a watchdog.
module painterengine_gpu_writer_scheduler #(
   parameter int PARAM_RESET_CYCLES   = 4,
   parameter int PARAM_TIMEOUT_CYCLES = 1048575
) (
   input  logic           i_wire_clock,
   input  logic           i_wire_reset,
   input  logic [3:0]     i_wire_req,
   input  logic [127:0]   i_wire_address,
   input  logic [127:0]   i_wire_length,
   output logic [3:0]     o_wire_ack,
   output logic [3:0]     o_wire_fail,
   output logic [2:0]     o_wire_error_type,
   output logic           o_wire_busy,
   output logic           o_wire_writer_resetn,
   output logic [3:0]     o_wire_writer_router,
   output logic [127:0]   o_wire_writer_address,
   output logic [127:0]   o_wire_writer_length,
   input  logic           i_wire_writer_done,
   input  logic           i_wire_writer_error,
   input  logic [2:0]     i_wire_writer_error_type
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RESET,
      ST_RUN,
      ST_REPORT
   } state_t;

   localparam logic [2:0]  ERR_TIMEOUT   = 3'b101;
   localparam logic [3:0]  RESET_LOAD    = 4'(PARAM_RESET_CYCLES - 1);
   localparam logic [19:0] WATCHDOG_LAST = 20'(PARAM_TIMEOUT_CYCLES - 1);

   state_t         state_q, state_d;
   logic [1:0]     rr_ptr_q, rr_ptr_d;
   logic [3:0]     rst_cnt_q, rst_cnt_d;
   logic [19:0]    watchdog_q, watchdog_d;
   logic [3:0]     ack_q, ack_d;
   logic [3:0]     fail_q, fail_d;
   logic [2:0]     error_type_q, error_type_d;
   logic           busy_q, busy_d;
   logic           writer_resetn_q, writer_resetn_d;
   logic [3:0]     router_q, router_d;
   logic [127:0]   address_q, address_d;
   logic [127:0]   length_q, length_d;

   logic           pick_valid;
   logic [1:0]     pick_idx;
   logic [1:0]     cand;

   // Search starts one past the last granted channel; k=4 wraps back to rr_ptr itself.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = rr_ptr_q;
      cand       = rr_ptr_q;
      for (int k = 1; k <= 4; k++) begin
         cand = rr_ptr_q + 2'(k);
         if (!pick_valid && i_wire_req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      // NOTE: every _d gets a hold/default value first so no path through the case infers a latch.
      state_d         = state_q;
      rr_ptr_d        = rr_ptr_q;
      rst_cnt_d       = rst_cnt_q;
      watchdog_d      = watchdog_q;
      ack_d           = 4'b0000;
      fail_d          = 4'b0000;
      error_type_d    = error_type_q;
      writer_resetn_d = writer_resetn_q;
      router_d        = router_q;
      address_d       = address_q;
      length_d        = length_q;

      unique case (state_q)
         ST_IDLE: begin
            writer_resetn_d = 1'b0;
            if (pick_valid) begin
               rr_ptr_d                              = pick_idx;
               router_d                              = 4'b0001 << pick_idx;
               address_d                             = '0;
               length_d                              = '0;
               address_d[{pick_idx, 5'd0} +: 32]     = i_wire_address[{pick_idx, 5'd0} +: 32];
               length_d[{pick_idx, 5'd0} +: 32]      = i_wire_length[{pick_idx, 5'd0} +: 32];
               rst_cnt_d                             = RESET_LOAD;
               state_d                               = ST_RESET;
            end
         end

         ST_RESET: begin
            if (rst_cnt_q == 4'd0) begin
               writer_resetn_d = 1'b1;
               watchdog_d      = '0;
               state_d         = ST_RUN;
            end else begin
               rst_cnt_d = rst_cnt_q - 4'd1;
            end
         end

         ST_RUN: begin
            watchdog_d = watchdog_q + 20'd1;
            // Error beats done, and any writer status beats watchdog expiry.
            if (i_wire_writer_error) begin
               error_type_d    = i_wire_writer_error_type;
               fail_d          = router_q;
               writer_resetn_d = 1'b0;
               state_d         = ST_REPORT;
            end else if (i_wire_writer_done) begin
               ack_d           = router_q;
               writer_resetn_d = 1'b0;
               state_d         = ST_REPORT;
            end else if (watchdog_q == WATCHDOG_LAST) begin
               error_type_d    = ERR_TIMEOUT;
               fail_d          = router_q;
               writer_resetn_d = 1'b0;
               state_d         = ST_REPORT;
            end
         end

         ST_REPORT: begin
            router_d  = 4'b0000;
            address_d = '0;
            length_d  = '0;
            state_d   = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_wire_clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (i_wire_reset) begin
         state_q         <= ST_IDLE;
         rr_ptr_q        <= 2'd3;
         rst_cnt_q       <= 4'd0;
         watchdog_q      <= 20'd0;
         ack_q           <= 4'b0000;
         fail_q          <= 4'b0000;
         error_type_q    <= 3'b000;
         busy_q          <= 1'b0;
         writer_resetn_q <= 1'b0;
         router_q        <= 4'b0000;
         address_q       <= '0;
         length_q        <= '0;
      end else begin
         state_q         <= state_d;
         rr_ptr_q        <= rr_ptr_d;
         rst_cnt_q       <= rst_cnt_d;
         watchdog_q      <= watchdog_d;
         ack_q           <= ack_d;
         fail_q          <= fail_d;
         error_type_q    <= error_type_d;
         busy_q          <= busy_d;
         writer_resetn_q <= writer_resetn_d;
         router_q        <= router_d;
         address_q       <= address_d;
         length_q        <= length_d;
      end
   end

   assign o_wire_ack            = ack_q;
   assign o_wire_fail           = fail_q;
   assign o_wire_error_type     = error_type_q;
   assign o_wire_busy           = busy_q;
   assign o_wire_writer_resetn  = writer_resetn_q;
   assign o_wire_writer_router  = router_q;
   assign o_wire_writer_address = address_q;
   assign o_wire_writer_length  = length_q;

endmodule

// File: tb/tb_painterengine_gpu_writer_scheduler.sv
// Directed bench for painterengine_gpu_writer_scheduler; the writer is played by the stimulus.
module tb_painterengine_gpu_writer_scheduler;

   localparam int RST_CYC = 4;
   localparam int TMO_CYC = 100;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [127:0] addr;
   logic [127:0] len;
   logic         wdone;
   logic         werr;
   logic [2:0]   wetype;

   logic [3:0]   ack;
   logic [3:0]   fail;
   logic [2:0]   error_type;
   logic         busy;
   logic         writer_resetn;
   logic [3:0]   router;
   logic [127:0] waddr;
   logic [127:0] wlen;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   painterengine_gpu_writer_scheduler #(
      .PARAM_RESET_CYCLES   (RST_CYC),
      .PARAM_TIMEOUT_CYCLES (TMO_CYC)
   ) dut (
      .i_wire_clock             (clk),
      .i_wire_reset             (rst),
      .i_wire_req               (req),
      .i_wire_address           (addr),
      .i_wire_length            (len),
      .o_wire_ack               (ack),
      .o_wire_fail              (fail),
      .o_wire_error_type        (error_type),
      .o_wire_busy              (busy),
      .o_wire_writer_resetn     (writer_resetn),
      .o_wire_writer_router     (router),
      .o_wire_writer_address    (waddr),
      .o_wire_writer_length     (wlen),
      .i_wire_writer_done       (wdone),
      .i_wire_writer_error      (werr),
      .i_wire_writer_error_type (wetype)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts cycles with resetn low (the grant cycle included) until it rises; bounded.
   task automatic wait_run(input string tag);
      int lows;
      lows = 1;
      while (writer_resetn !== 1'b1 && lows < 20) begin
         tick();
         if (writer_resetn !== 1'b1) lows++;
      end
      check({tag, " reset_low_cycles"}, 128'(lows), 128'(RST_CYC));
   endtask

   task automatic apply_reset(input string tag);
      rst = 1'b1;
      tick();
      tick();
      check({tag, " resetn"},  128'(writer_resetn), 128'(1'b0));
      check({tag, " router"},  128'(router),        128'(4'b0000));
      check({tag, " busy"},    128'(busy),          128'(1'b0));
      check({tag, " ackfail"}, 128'({ack, fail}),   128'(8'h00));
      check({tag, " errtype"}, 128'(error_type),    128'(3'b000));
      check({tag, " addrlen"}, waddr | wlen,        128'(0));
      rst = 1'b0;
   endtask

   // Grants one job, lets it run run_ticks RUN cycles, then presents writer status.
   task automatic do_job(input string tag, input logic [3:0] exp_router, input int run_ticks,
                         input logic d, input logic e, input logic [2:0] et, input logic exp_ack);
      logic [127:0] ea;
      logic [127:0] el;
      logic         early;
      ea = '0;
      el = '0;
      for (int i = 0; i < 4; i++)
         if (exp_router[i]) begin
            ea[32*i +: 32] = addr[32*i +: 32];
            el[32*i +: 32] = len[32*i +: 32];
         end
      tick();
      check({tag, " grant_router"}, 128'(router), 128'(exp_router));
      check({tag, " grant_busy"},   128'(busy),   128'(1'b1));
      check({tag, " slot_address"}, waddr,        ea);
      check({tag, " slot_length"},  wlen,         el);
      wait_run(tag);
      early = 1'b0;
      repeat (run_ticks) begin
         tick();
         if (ack !== 4'b0000 || fail !== 4'b0000 || writer_resetn !== 1'b1) early = 1'b1;
      end
      check({tag, " no_early_end"}, 128'(early), 128'(1'b0));
      wdone  = d;
      werr   = e;
      wetype = et;
      tick();
      check({tag, " ack_pulse"},     128'(ack),           128'(exp_ack ? exp_router : 4'b0000));
      check({tag, " fail_pulse"},    128'(fail),          128'(exp_ack ? 4'b0000 : exp_router));
      check({tag, " report_resetn"}, 128'(writer_resetn), 128'(1'b0));
      wdone  = 1'b0;
      werr   = 1'b0;
      wetype = 3'b000;
      req    = req & ~exp_router;
      tick();
      check({tag, " pulse_cleared"}, 128'({ack, fail}), 128'(8'h00));
      check({tag, " idle_busy"},     128'(busy),        128'(1'b0));
      check({tag, " idle_router"},   128'(router),      128'(4'b0000));
      check({tag, " idle_slots"},    waddr | wlen,      128'(0));
   endtask

   initial begin
      rst    = 1'b1;
      req    = 4'b0000;
      addr   = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
      len    = {32'd64, 32'd48, 32'd32, 32'd16};
      wdone  = 1'b0;
      werr   = 1'b0;
      wetype = 3'b000;

      apply_reset("por");

      // Single job on channel 0, done 40 cycles after resetn rises.
      req = 4'b0001;
      do_job("single", 4'b0001, 39, 1'b1, 1'b0, 3'b000, 1'b1);

      // Round robin from a fresh reset, then restart at channel 0.
      apply_reset("rr_reset");
      req = 4'b1111;
      do_job("rr0", 4'b0001, 3, 1'b1, 1'b0, 3'b000, 1'b1);
      do_job("rr1", 4'b0010, 3, 1'b1, 1'b0, 3'b000, 1'b1);
      do_job("rr2", 4'b0100, 3, 1'b1, 1'b0, 3'b000, 1'b1);
      do_job("rr3", 4'b1000, 3, 1'b1, 1'b0, 3'b000, 1'b1);
      req = 4'b1111;
      do_job("rr_restart", 4'b0001, 3, 1'b1, 1'b0, 3'b000, 1'b1);

      // Writer error code is reported and held through a later success.
      req = 4'b0100;
      do_job("werr", 4'b0100, 5, 1'b0, 1'b1, 3'b010, 1'b0);
      check("werr type", 128'(error_type), 128'(3'b010));
      req = 4'b1000;
      do_job("after_err", 4'b1000, 5, 1'b1, 1'b0, 3'b000, 1'b1);
      check("after_err type_held", 128'(error_type), 128'(3'b010));

      // Watchdog expiry on the 100th RUN cycle, then done on that same final cycle.
      req = 4'b0001;
      do_job("timeout", 4'b0001, TMO_CYC - 1, 1'b0, 1'b0, 3'b000, 1'b0);
      check("timeout type", 128'(error_type), 128'(3'b101));
      req = 4'b0010;
      do_job("done_last", 4'b0010, TMO_CYC - 1, 1'b1, 1'b0, 3'b000, 1'b1);
      check("done_last type_held", 128'(error_type), 128'(3'b101));

      // Done and error together reports fail with the writer's code.
      req = 4'b0100;
      do_job("done_err", 4'b0100, 5, 1'b1, 1'b1, 3'b011, 1'b0);
      check("done_err type", 128'(error_type), 128'(3'b011));

      // Reset during RUN drops the pending completion and restarts arbitration.
      req = 4'b0010;
      tick();
      check("midrst grant_router", 128'(router), 128'(4'b0010));
      wait_run("midrst");
      repeat (3) tick();
      wdone = 1'b1;
      rst   = 1'b1;
      tick();
      check("midrst resetn",  128'(writer_resetn), 128'(1'b0));
      check("midrst router",  128'(router),        128'(4'b0000));
      check("midrst ackfail", 128'({ack, fail}),   128'(8'h00));
      check("midrst busy",    128'(busy),          128'(1'b0));
      check("midrst errtype", 128'(error_type),    128'(3'b000));
      rst   = 1'b0;
      wdone = 1'b0;
      req   = 4'b1111;
      do_job("post_rst", 4'b0001, 3, 1'b1, 1'b0, 3'b000, 1'b1);
      req = 4'b0000;
      tick();
      check("final idle_busy", 128'(busy), 128'(1'b0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
